mp_add_seq: RTL
===============

MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 Parameter NWORDS, default 4: number of 32-bit words per operand; legal range 2..16.
REQ-002 Parameter W, default 32: word width of the shared adder datapath; fixed at 32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 mode  input  1  0 = integer add with carry chain, 1 = GF(2) carry-less add (XOR).
REQ-008 carry_option  input  1  integer-mode carry-in to word 0; ignored when mode=1.
REQ-009 a  input  W*NWORDS  operand A, word 0 = bits [31:0].
REQ-010 b  input  W*NWORDS  operand B, same packing.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  W*NWORDS  result, same packing.
REQ-014 carry_out  output  1  integer-mode carry out of the top word; 0 in GF mode.

Function
REQ-015 The block SHALL contain exactly one W-bit adder datapath and process one word per clock, LSW first.
REQ-016 FSM states SHALL be IDLE, RUN and DONE, with no other reachable states.
REQ-017 IDLE: in_ready=1; on in_valid=1, SHALL capture a, b, mode and carry_option, clear sum and word index to 0, load carry register with carry_option&~mode, and go to RUN.
REQ-018 In any state other than IDLE, in_ready SHALL be 0, and in_valid SHALL be ignored without side effect.
REQ-019 RUN, mode 0: each edge SHALL write sum word[idx] = A[idx]+B[idx]+carry (mod 2^32), set carry = bit 32 of that addition, and increment idx.
REQ-020 RUN, mode 1: each edge SHALL write sum word[idx] = A[idx]^B[idx], hold carry at 0, and increment idx.
REQ-021 On the edge that processes idx=NWORDS-1, the FSM SHALL go to DONE, set out_valid=1 and set carry_out = final carry.
REQ-022 Latency: out_valid SHALL rise exactly NWORDS edges after the accepting edge.
REQ-023 DONE: sum, carry_out and out_valid SHALL hold stable while out_ready=0 for any number of cycles.
REQ-024 DONE with out_ready=1: on that edge the FSM SHALL go to IDLE and clear out_valid; sum and carry_out SHALL retain their values until the next accept.
REQ-025 Back-to-back operation: the minimum accept-to-accept interval SHALL be NWORDS+2 cycles.
REQ-026 Within RUN, changes on a, b, mode or carry_option SHALL NOT affect the result in progress.
REQ-027 The word index SHALL be ceil(log2(NWORDS)) bits wide, and SHALL NOT wrap past NWORDS-1 within an operation.

Reset
REQ-028 rst=1 SHALL immediately, independent of clk, force: state=IDLE, idx=0, carry=0, sum=0, carry_out=0, out_valid=0; in_ready SHALL then read 1.
REQ-029 rst asserted during RUN or DONE SHALL abort the operation, with no partial result presented after release.
REQ-030 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-031 Integer wrap, NWORDS=4, mode=0, carry_option=0, a=128'hFFFF..FF, b=128'h1 -> sum=0, carry_out=1, out_valid rises 4 edges after accept.
REQ-032 GF mode, a=128'hF0F0..F0, b=128'hFFFF..FF, carry_option=1 -> sum=128'h0F0F..0F, carry_out=0 (carry_option ignored).
REQ-033 Carry-in, mode=0, carry_option=1, a=b=0 -> sum=128'h1, carry_out=0; mid-chain a=128'h0000_0000_FFFF_FFFF, b=128'h1 -> sum=128'h1_0000_0000.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE, while toggling in_valid and inputs -> sum/carry_out/out_valid unchanged, in_ready=0, no second accept.
REQ-035 Reset mid-run: assert rst asynchronously after 2 RUN edges -> outputs zero within the same cycle, out_valid=0, in_ready=1; a new operation then completes correctly.
REQ-036 Random streaming: 1000 random operand sets with random mode and random out_ready -> every result matches the reference model, and accept spacing is at least NWORDS+2 cycles.

Source files
------------

// File: rtl/mp_add_seq.sv
// Sequential multi-word adder: one 32-bit word per clock, LSW first, integer
// (carry chain) or GF(2) carry-less mode, valid/ready on both sides.
module mp_add_seq #(
    parameter int NWORDS = 4,
    parameter int W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic                  carry_option,
    input  logic [W*NWORDS-1:0]   a,
    input  logic [W*NWORDS-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W*NWORDS-1:0]   sum,
    output logic                  carry_out
);

    localparam int             IW       = $clog2(NWORDS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;

    logic [NWORDS-1:0][W-1:0]   a_q;
    logic [NWORDS-1:0][W-1:0]   b_q;
    logic [NWORDS-1:0][W-1:0]   sum_q;
    logic                       mode_q;
    logic                       carry_q;
    logic                       carry_out_q;
    logic [IW-1:0]              idx;

    logic [W:0]                 add_res;
    logic [W-1:0]               word_res;
    logic                       carry_nxt;
    logic                       last_word;
    logic                       accept;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_word) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    assign accept    = (state == IDLE) && in_valid;
    assign last_word = (idx == LAST_IDX);

    // The single shared word adder; XOR path bypasses it in GF(2) mode.
    always_comb begin
        add_res = {1'b0, a_q[idx]} + {1'b0, b_q[idx]} + {{W{1'b0}}, carry_q};
        if (mode_q) begin
            word_res  = a_q[idx] ^ b_q[idx];
            carry_nxt = 1'b0;
        end else begin
            word_res  = add_res[W-1:0];
            carry_nxt = add_res[W];
        end
    end

    // NOTE: operand holding registers are deliberately not reset; they are
    // only read in RUN, which is always entered through a capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            idx         <= '0;
            sum_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        carry_q     <= carry_option & ~mode;
                        carry_out_q <= 1'b0;
                        idx         <= '0;
                        sum_q       <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx] <= word_res;
                    carry_q    <= carry_nxt;
                    // Index parks on the last word instead of wrapping.
                    if (last_word) begin
                        carry_out_q <= carry_nxt;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule
